// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit on a word-addressed data bus.
// Optional macro MISALIGN_TRAP_EN: trap misaligned half/word accesses.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        lsu_stall,
    output logic        dbus_req_valid,
    input  logic        dbus_req_ready,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_rsp_valid,
    input  logic [31:0] dbus_rsp_rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
`ifdef MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    output logic        bus_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] TO_LAST =
        CW'(TIMEOUT_CYCLES == 0 ? 32'd0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] ld_q, ld_d;
    logic        lv_q, lv_d;
    logic        err_q, err_d;
`ifdef MISALIGN_TRAP_EN
    logic        mis_q, mis_d;
`endif

    logic        access;
    logic        mis;
    logic [3:0]  be_new;
    logic [31:0] wd_new;
    logic [7:0]  rb;
    logic [15:0] rh;
    logic [31:0] ext;
    logic        req;

    assign access = mem_read | mem_write;
    assign req    = (state_q == REQ);

`ifdef MISALIGN_TRAP_EN
    assign mis = (mem_funct3[1:0] == 2'b01 && mem_addr[0]) ||
                 (mem_funct3[1] && mem_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    // Byte enables and lane replication for the incoming access size
    always_comb begin
        be_new = 4'b1111;
        wd_new = mem_wdata;
        unique case (1'b1)
            mem_funct3[1:0] == 2'b00: begin
                be_new = 4'b0001 << mem_addr[1:0];
                wd_new = {4{mem_wdata[7:0]}};
            end
            mem_funct3[1:0] == 2'b01: begin
                be_new = 4'b0011 << {mem_addr[1], 1'b0};
                wd_new = {2{mem_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Select the addressed lane of the read word and size-extend it
    always_comb begin
        rb  = dbus_rsp_rdata[{off_q, 3'b000} +: 8];
        rh  = dbus_rsp_rdata[{off_q[1], 4'b0000} +: 16];
        ext = dbus_rsp_rdata;
        unique case (f3_q)
            3'b000:  ext = {{24{rb[7]}}, rb};
            3'b001:  ext = {{16{rh[15]}}, rh};
            3'b100:  ext = {24'b0, rb};
            3'b101:  ext = {16'b0, rh};
            default: ext = dbus_rsp_rdata;
        endcase
    end

    // Access sequencing: next state, latched fields, stall
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        off_d     = off_q;
        ld_d      = '0;
        lv_d      = 1'b0;
        err_d     = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis_d     = 1'b0;
`endif
        lsu_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    lsu_stall = 1'b1;
                    we_d      = mem_write;
                    addr_d    = mem_addr[31:2];
                    be_d      = be_new;
                    wdata_d   = wd_new;
                    f3_d      = mem_funct3;
                    off_d     = mem_addr[1:0];
                    if (mis) begin
                        state_d = DONE;
                        lv_d    = 1'b1;
`ifdef MISALIGN_TRAP_EN
                        mis_d   = 1'b1;
`endif
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                lsu_stall = 1'b1;
                if (dbus_req_ready) state_d = WAIT;
            end
            WAIT: begin
                lsu_stall = 1'b1;
                cnt_d     = cnt_q + CW'(1);
                if (dbus_rsp_valid) begin
                    state_d = DONE;
                    lv_d    = 1'b1;
                    ld_d    = we_q ? 32'h0 : ext;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                    state_d = DONE;
                    lv_d    = 1'b1;
                    err_d   = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched access fields and registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            ld_q    <= '0;
            lv_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            ld_q    <= ld_d;
            lv_q    <= lv_d;
            err_q   <= err_d;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign dbus_req_valid = req;
    assign dbus_we        = req & we_q;
    assign dbus_addr      = req ? {addr_q, 2'b00} : 32'h0;
    assign dbus_be        = req ? be_q : 4'h0;
    assign dbus_wdata     = req ? wdata_q : 32'h0;
    assign load_data      = ld_q;
    assign load_valid     = lv_q;
    assign bus_error      = err_q;
`ifdef MISALIGN_TRAP_EN
    assign misaligned     = mis_q;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: table vectors, directed corner sequences and a
// randomized run against an arithmetic reference model of mem_stage_lsu.
module tb_mem_stage_lsu;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic        mem_read;
    logic        mem_write;
    logic        lsu_stall;
    logic        dbus_req_valid;
    logic        dbus_req_ready;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_rsp_valid;
    logic [31:0] dbus_rsp_rdata;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_error;
`ifdef MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_funct3     (mem_funct3),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .lsu_stall      (lsu_stall),
        .dbus_req_valid (dbus_req_valid),
        .dbus_req_ready (dbus_req_ready),
        .dbus_we        (dbus_we),
        .dbus_addr      (dbus_addr),
        .dbus_be        (dbus_be),
        .dbus_wdata     (dbus_wdata),
        .dbus_rsp_valid (dbus_rsp_valid),
        .dbus_rsp_rdata (dbus_rsp_rdata),
        .load_data      (load_data),
        .load_valid     (load_valid),
`ifdef MISALIGN_TRAP_EN
        .misaligned     (misaligned),
`endif
        .bus_error      (bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        rd;
        logic        wr;
        int          rdy;
        int          rsp;
        logic        we;
        logic [3:0]  be;
        logic [31:0] xwd;
        logic [31:0] ld;
        logic        err;
        logic        mis;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, input logic rd,
                                input logic wr, input logic [31:0] rdata,
                                input int rdy, input int rsp, input logic we,
                                input logic [3:0] be, input logic [31:0] xwd,
                                input logic [31:0] ld, input logic err);
        vec_t v;
        v.f3 = f3; v.addr = a; v.wdata = d; v.rd = rd; v.wr = wr;
        v.rdata = rdata; v.rdy = rdy; v.rsp = rsp; v.we = we; v.be = be;
        v.xwd = xwd; v.ld = ld; v.err = err; v.mis = 1'b0;
        return v;
    endfunction

    // Reference: size, lane offset, mask and extension by plain arithmetic
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int unsigned sz, off, mask, val, rep;
        r = v;
        sz = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
        if (sz == 4) off = 0;
        else if (sz == 2) off = v.addr % 4 & 2;
        else off = v.addr % 4;
        mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 1;
        rep  = (sz == 1) ? 32'h0101_0101 : (sz == 2) ? 32'h0001_0001 : 1;
        r.mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        r.mis = (v.addr % sz) != 0;
`endif
        r.we  = v.wr;
        r.be  = 4'(((1 << sz) - 1) << off);
        r.xwd = (v.wdata & mask) * rep;
        val = (v.rdata >> (8 * off)) & mask;
        if ((v.f3 == 3'd0 || v.f3 == 3'd1) && ((val >> (8 * sz - 1)) & 1) == 1)
            val = val | ~mask;
        r.err = !r.mis && v.rsp >= TO;
        r.ld  = (r.mis || r.err || v.wr) ? 32'h0 : val;
        return r;
    endfunction

    // Present one access, act as the bus slave, check the outcome
    task automatic run_access(input vec_t v, input string nm);
        int stall_n = 0;
        int req_n = 0;
        int wait_n = 0;
        int exp_wait, exp_stall, exp_req;
        bit acc = 0, done = 0, unstable = 0;
        logic        f_we;
        logic [31:0] f_addr, f_wd;
        logic [3:0]  f_be;
        f_we = 0; f_addr = 0; f_wd = 0; f_be = 0;
        @(negedge clk);
        mem_funct3 = v.f3; mem_addr = v.addr; mem_wdata = v.wdata;
        mem_read = v.rd; mem_write = v.wr;
        dbus_req_ready = 0; dbus_rsp_valid = 0; dbus_rsp_rdata = v.rdata;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            if (load_valid) begin
                done = 1;
                chk({nm, " load_data"}, load_data, v.ld);
                chk({nm, " bus_error"}, 32'(bus_error), 32'(v.err));
                chk({nm, " stall@done"}, 32'(lsu_stall), 0);
`ifdef MISALIGN_TRAP_EN
                chk({nm, " misaligned"}, 32'(misaligned), 32'(v.mis));
`endif
            end else begin
                if (lsu_stall) stall_n++;
                dbus_req_ready = 0;
                dbus_rsp_valid = 0;
                if (dbus_req_valid) begin
                    if (req_n == 0) begin
                        f_we = dbus_we; f_addr = dbus_addr;
                        f_be = dbus_be; f_wd = dbus_wdata;
                    end else if ({f_we, f_addr, f_be, f_wd} !==
                                 {dbus_we, dbus_addr, dbus_be, dbus_wdata}) begin
                        unstable = 1;
                    end
                    req_n++;
                    dbus_req_ready = (req_n > v.rdy);
                    if (dbus_req_ready) acc = 1;
                end else if (acc) begin
                    dbus_rsp_valid = (wait_n == v.rsp);
                    wait_n++;
                end
            end
            @(negedge clk);
        end
        mem_read = 0; mem_write = 0;
        dbus_req_ready = 0; dbus_rsp_valid = 0;
        chk({nm, " completed"}, 32'(done), 1);
        exp_wait  = (v.rsp < TO) ? v.rsp + 1 : TO;
        exp_stall = v.mis ? 1 : 1 + (v.rdy + 1) + exp_wait;
        exp_req   = v.mis ? 0 : v.rdy + 1;
        chk({nm, " stall_cycles"}, 32'(stall_n), 32'(exp_stall));
        chk({nm, " req_cycles"}, 32'(req_n), 32'(exp_req));
        if (!v.mis) begin
            chk({nm, " we"}, 32'(f_we), 32'(v.we));
            chk({nm, " addr"}, f_addr, {v.addr[31:2], 2'b00});
            chk({nm, " be"}, 32'(f_be), 32'(v.be));
            if (v.wr) chk({nm, " wdata"}, f_wd, v.xwd);
            chk({nm, " req_stable"}, 32'(unstable), 0);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " ctl"}, 32'({lsu_stall, dbus_req_valid, dbus_we,
                              load_valid, bus_error}), 0);
        chk({nm, " addr"}, dbus_addr, 0);
        chk({nm, " be"}, 32'(dbus_be), 0);
        chk({nm, " wdata"}, dbus_wdata, 0);
        chk({nm, " load_data"}, load_data, 0);
`ifdef MISALIGN_TRAP_EN
        chk({nm, " misaligned"}, 32'(misaligned), 0);
`endif
    endtask

    vec_t tbl[13];

    initial begin
        bit   late_lv;
        vec_t rv;
        int   sel;

        tbl[0]  = mk(3'b000, 32'h1003, 32'hA5, 0, 1, 32'h0, 0, 0,
                     1, 4'b1000, 32'hA5A5_A5A5, 32'h0, 0);
        tbl[1]  = mk(3'b001, 32'h2002, 32'h0, 1, 0, 32'h8001_1234, 0, 0,
                     0, 4'b1100, 32'h0, 32'hFFFF_8001, 0);
        tbl[2]  = mk(3'b101, 32'h2002, 32'h0, 1, 0, 32'h8001_1234, 0, 0,
                     0, 4'b1100, 32'h0, 32'h0000_8001, 0);
        tbl[3]  = mk(3'b000, 32'h2001, 32'h0, 1, 0, 32'h0000_F200, 0, 0,
                     0, 4'b0010, 32'h0, 32'hFFFF_FFF2, 0);
        tbl[4]  = mk(3'b010, 32'h2000, 32'h0, 1, 0, 32'h0000_F200, 0, 0,
                     0, 4'b1111, 32'h0, 32'h0000_F200, 0);
        tbl[5]  = mk(3'b010, 32'h3000, 32'h1234_5678, 0, 1, 32'h0, 5, 0,
                     1, 4'b1111, 32'h1234_5678, 32'h0, 0);
        tbl[6]  = mk(3'b010, 32'h4000, 32'h0, 1, 0, 32'h55, 0, 9,
                     0, 4'b1111, 32'h0, 32'h0, 1);
        tbl[7]  = mk(3'b001, 32'h1006, 32'hBEEF_CAFE, 0, 1, 32'h0, 1, 1,
                     1, 4'b1100, 32'hCAFE_CAFE, 32'h0, 0);
        tbl[8]  = mk(3'b100, 32'h1003, 32'h0, 1, 0, 32'h9A00_0000, 0, 2,
                     0, 4'b1000, 32'h0, 32'h0000_009A, 0);
        tbl[9]  = mk(3'b000, 32'h0001, 32'h77, 1, 1, 32'hFFFF_FFFF, 0, 0,
                     1, 4'b0010, 32'h7777_7777, 32'h0, 0);
        tbl[10] = mk(3'b011, 32'h0008, 32'hDEAD_BEEF, 0, 1, 32'h0, 2, 0,
                     1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0);
        tbl[11] = mk(3'b001, 32'h0010, 32'h0, 1, 0, 32'h0000_7FFF, 0, 3,
                     0, 4'b0011, 32'h0, 32'h0000_7FFF, 0);
        tbl[12] = mk(3'b000, 32'h0002, 32'h3C, 0, 1, 32'h0, 0, 7,
                     1, 4'b0100, 32'h3C3C_3C3C, 32'h0, 1);

        rst = 1;
        mem_addr = 0; mem_wdata = 0; mem_funct3 = 0;
        mem_read = 0; mem_write = 0;
        dbus_req_ready = 0; dbus_rsp_valid = 0; dbus_rsp_rdata = 0;
        #3;
        chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk_zero("post_reset");

        for (int i = 0; i < 13; i++)
            run_access(tbl[i], $sformatf("vec%0d", i));

        // Reset pulse while waiting for a response
        @(negedge clk);
        mem_funct3 = 3'b010; mem_addr = 32'h5004; mem_wdata = 32'hFFFF_0000;
        mem_write = 1;
        @(negedge clk);
        #1;
        chk("rstseq in_req", 32'(dbus_req_valid), 1);
        dbus_req_ready = 1;
        @(negedge clk);
        dbus_req_ready = 0;
        mem_write = 0;
        #1;
        chk("rstseq in_wait", 32'({lsu_stall, dbus_req_valid}), 32'b10);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        chk_zero("rstseq");
        dbus_rsp_valid = 1;
        dbus_rsp_rdata = 32'h1234_5678;
        @(negedge clk);
        dbus_rsp_valid = 0;
        late_lv = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (load_valid || lsu_stall) late_lv = 1;
            @(negedge clk);
        end
        chk("late_rsp ignored", 32'(late_lv), 0);
        run_access(tbl[3], "after_rst");

`ifdef MISALIGN_TRAP_EN
        rv = mk(3'b010, 32'h1002, 32'h0, 1, 0, 32'hFFFF_FFFF, 0, 0,
                0, 4'b0, 32'h0, 32'h0, 0);
        rv.mis = 1;
        run_access(rv, "mis_lw");
`endif

        for (int i = 0; i < 200; i++) begin
            sel      = $urandom_range(1, 3);
            rv.f3    = 3'($urandom_range(0, 7));
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.rd    = sel[0];
            rv.wr    = sel[1];
            rv.rdy   = $urandom_range(0, 3);
            rv.rsp   = $urandom_range(0, 5);
            rv       = model(rv);
            run_access(rv, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
